mod_reconstruct: RTL and testbench
==================================

// Module: mod_reconstruct
// PURPOSE
//  Inverse of the sequential N-mod-M unit: rebuilds N = Q*M + R from quotient Q, modulus M, residue R.
//  Sequential shift-add over the MW bits of M, one bit per clock; start/busy/done handshake.
//  Sits on the decode side of the SNTRUP757 coefficient path; lifts reduced coefficients back to 13-bit signed.
// PARAMETERS
//  NW  13  width of signed result n_out and of signed quotient q_in
//  MW   4  width of unsigned modulus m_in and residue r_in; also number of CALC cycles
// PORTS
//  clk    in   1   clock, rising edge
//  rst_n  in   1   asynchronous active-low reset
//  start  in   1   request; sampled only in IDLE
//  q_in   in   NW  signed quotient Q
//  m_in   in   MW  unsigned modulus M
//  r_in   in   MW  unsigned residue R
//  busy   out  1   high while an operation is in progress (CALC and DONE)
//  done   out  1   one-cycle pulse; n_out and err valid in that cycle
//  n_out  out  NW  signed result, registered; holds until next done
//  err    out  1   range/overflow flag, valid with done (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n=0, any time incl. mid-operation): state=IDLE; busy=0, done=0, n_out=0, err=0; internal acc/count cleared.
//  FSM states: IDLE, CALC, DONE.
//  IDLE: start=1 -> capture q_in, m_in, r_in; acc <= zero-extended R; cnt <= 0; -> CALC. start=0 -> stay.
//  CALC: if m_reg[cnt]=1, acc <= acc + (sign-extended Q << cnt); cnt <= cnt+1; cnt==MW-1 -> DONE.
//  DONE: n_out <= acc[NW-1:0]; err updated; done=1 for this cycle only; -> IDLE.
//  Timing: start sampled at edge t -> busy high for t+1..t+MW+1; CALC occupies t+1..t+MW; done at t+MW+1.
//  Latency MW+1 cycles (5 with defaults). Back-to-back: next start accepted in cycle after done.
//  start while busy (CALC or DONE) ignored, not queued. Inputs may change freely after capture.
//  Arithmetic: acc is signed NW+MW+1 bits; no intermediate overflow possible.
//  Result wraps: n_out = low NW bits of Q*M+R (two's complement) when the true value exceeds NW signed range.
//  M=0: no additions; n_out = R. R is never reduced by M.
// CONFIGURATION
//  Macro MODREC_CHECK_EN.
//  Defined: err=1 with done if M==0, or R>=M, or acc outside [-2^(NW-1), 2^(NW-1)-1]; else err=0.
//           n_out still carries the wrapped result; no extra latency.
//  Undefined: no check logic; err tied to 0; n_out unchanged.
// TESTING
//  Q=5, M=7, R=3, start at t -> done at t+5, n_out=38, err=0.
//  Q=-3, M=5, R=4 -> n_out=-11, err=0.
//  Q=1000, M=15, R=0 -> n_out=-1384 (15000 wrapped to 13b); err=1 if MODREC_CHECK_EN else 0.
//  Q=2, M=7, R=9 -> n_out=23; err=1 with macro. Q=4, M=0, R=3 -> n_out=3; err=1 with macro.
//  start re-pulsed at t+2 with other operands -> ignored; done at t+5 only, result of first operands.
//  rst_n low during CALC -> busy, done, n_out, err all 0 immediately; no done pulse; fresh start works normally.

Source files
------------

// File: rtl/mod_reconstruct.sv
// mod_reconstruct: rebuilds N = Q*M + R by sequential shift-add over the MW bits of M.
// Optional range checking is enabled with the macro MODREC_CHECK_EN.
module mod_reconstruct #(
    parameter int NW = 13,
    parameter int MW = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic signed [NW-1:0] q_in,
    input  logic        [MW-1:0] m_in,
    input  logic        [MW-1:0] r_in,
    output logic                 busy,
    output logic                 done,
    output logic signed [NW-1:0] n_out,
    output logic                 err
);
    localparam int AW = NW + MW + 1;
    localparam int CW = (MW > 1) ? $clog2(MW) : 1;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t               state_q;
    logic signed [NW-1:0] q_q;
    logic        [MW-1:0] m_q;
    logic        [CW-1:0] cnt_q;
    logic signed [AW-1:0] acc_q, acc_d, q_ext;
    logic                 err_d;
    assign q_ext = {{(AW-NW){q_q[NW-1]}}, q_q};
    assign acc_d = m_q[cnt_q] ? acc_q + (q_ext <<< cnt_q) : acc_q;
`ifdef MODREC_CHECK_EN
    localparam logic signed [AW-1:0] MAXV = AW'((1 << (NW-1)) - 1);
    localparam logic signed [AW-1:0] MINV = -AW'(1 << (NW-1));
    logic bad_rm_q;
    assign err_d = bad_rm_q || (acc_d > MAXV) || (acc_d < MINV);
`else
    assign err_d = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            n_out   <= '0;
            err     <= 1'b0;
`ifdef MODREC_CHECK_EN
            bad_rm_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        q_q     <= q_in;
                        m_q     <= m_in;
                        acc_q   <= AW'(r_in);
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= CALC;
`ifdef MODREC_CHECK_EN
                        bad_rm_q <= (m_in == '0) || (r_in >= m_in);
`endif
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    // last addition lands straight in n_out so done and the result share a cycle
                    if (cnt_q == CW'(MW-1)) begin
                        state_q <= DONE;
                        done    <= 1'b1;
                        n_out   <= acc_d[NW-1:0];
                        err     <= err_d;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mod_reconstruct.sv
// tb_mod_reconstruct: directed vector table plus handshake/reset corner sequences for mod_reconstruct.
module tb_mod_reconstruct;
    localparam int NW = 13;
    localparam int MW = 4;
`ifdef MODREC_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic signed [NW-1:0] q_in = '0;
    logic        [MW-1:0] m_in = '0;
    logic        [MW-1:0] r_in = '0;
    logic                 busy, done, err;
    logic signed [NW-1:0] n_out;
    int total = 0;
    int bad = 0;

    mod_reconstruct #(.NW(NW), .MW(MW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .q_in(q_in), .m_in(m_in),
        .r_in(r_in), .busy(busy), .done(done), .n_out(n_out), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {int q; int m; int r; int n; bit e;} vec_t;
    vec_t v[12];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic op(input int q, input int m, input int r, output int n, output bit e, output int lat);
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        start = 1'b1; q_in = NW'(q); m_in = MW'(m); r_in = MW'(r);
        @(negedge clk);
        start = 1'b0; q_in = 13'h0aaa; m_in = 4'h9; r_in = 4'h6;
        lat = 1;
        while (!done && lat < 20) begin
            chk("calc_busy", int'(busy), 1);
            @(negedge clk);
            lat++;
        end
        chk("done_busy", int'(busy), 1);
        n = int'(n_out);
        e = err;
    endtask

    initial begin
        int n, lat, cyc;
        bit e, seen;
        v[0]  = '{5, 7, 3, 38, 0};
        v[1]  = '{-3, 5, 4, -11, 0};
        v[2]  = '{1000, 15, 0, -1384, 1};
        v[3]  = '{2, 7, 9, 23, 1};
        v[4]  = '{4, 0, 3, 3, 1};
        v[5]  = '{0, 1, 0, 0, 0};
        v[6]  = '{-4096, 1, 0, -4096, 0};
        v[7]  = '{4095, 1, 0, 4095, 0};
        v[8]  = '{4095, 1, 1, -4096, 1};
        v[9]  = '{-4096, 15, 14, -4082, 1};
        v[10] = '{-1, 15, 14, -1, 0};
        v[11] = '{100, 8, 7, 807, 0};

        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_n_out", int'(n_out), 0);
        chk("rst_err", int'(err), 0);
        rst_n = 1'b1;

        foreach (v[i]) begin
            op(v[i].q, v[i].m, v[i].r, n, e, lat);
            chk($sformatf("lat[%0d]", i), lat, MW + 1);
            chk($sformatf("n[%0d]", i), n, v[i].n);
            chk($sformatf("err[%0d]", i), int'(e), int'(v[i].e & CHK));
        end

        // start re-pulsed mid-operation and during the done cycle is ignored
        @(negedge clk);
        start = 1'b1; q_in = 13'sd5; m_in = 4'd7; r_in = 4'd3;
        @(negedge clk);
        start = 1'b0; lat = 1;
        @(negedge clk);
        lat++;
        start = 1'b1; q_in = 13'sd9; m_in = 4'd9; r_in = 4'd1;
        @(negedge clk);
        start = 1'b0; lat++;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("repulse_lat", lat, MW + 1);
        chk("repulse_n", int'(n_out), 38);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("repulse_done_ignored_busy", int'(busy), 0);
        chk("repulse_done_ignored_done", int'(done), 0);
        chk("repulse_hold_n", int'(n_out), 38);

        // asynchronous reset in the middle of CALC
        @(negedge clk);
        start = 1'b1; q_in = 13'sd100; m_in = 4'd8; r_in = 4'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_n_out", int'(n_out), 0);
        chk("midrst_err", int'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            seen |= done | busy;
        end
        chk("midrst_no_done", int'(seen), 0);
        op(-3, 5, 4, n, e, lat);
        chk("post_rst_lat", lat, MW + 1);
        chk("post_rst_n", n, -11);
        chk("post_rst_err", int'(e), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
